serial_mag_comp_ctrl: RTL

Bit-serial magnitude comparator controller for two WIDTH-bit unsigned operands. It latches both operands on a start handshake and steps a single 1-bit greater/less/equal compare from MSB to LSB, one bit per clock. It stops at the first differing bit and reports gt/lt/eq with a one-cycle done pulse. It replaces a wide cascaded comparator tree where area matters more than latency.

---
 rtl/serial_mag_comp_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/serial_mag_comp_ctrl.sv
// Bit-serial unsigned magnitude comparator: MSB-first, one bit per clock.
// Ports: clk/rst, start+a/b in; busy, done pulse, gt/lt/eq, bits_cmp out.
module serial_mag_comp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     busy,
  output logic                     done,
  output logic                     gt,
  output logic                     lt,
  output logic                     eq,
  output logic [$clog2(WIDTH):0]   bits_cmp
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_nxt;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq;
  logic             w_gt_nxt;
  logic             w_lt_nxt;
  logic             w_eq_nxt;
  logic [CW-1:0]    r_bits;
  logic [CW-1:0]    w_bits_nxt;
  logic             w_ba;
  logic             w_bb;
  logic             w_last;

  assign w_ba   = r_a[r_idx];
  assign w_bb   = r_b[r_idx];
  assign w_last = (r_idx == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
      r_bits  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_idx   <= w_idx_nxt;
      r_gt    <= w_gt_nxt;
      r_lt    <= w_lt_nxt;
      r_eq    <= w_eq_nxt;
      r_bits  <= w_bits_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_idx_nxt   = r_idx;
    w_gt_nxt    = r_gt;
    w_lt_nxt    = r_lt;
    w_eq_nxt    = r_eq;
    w_bits_nxt  = r_bits;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_idx_nxt   = IW'(WIDTH - 1);
          w_gt_nxt    = 1'b0;
          w_lt_nxt    = 1'b0;
          w_eq_nxt    = 1'b0;
          w_bits_nxt  = '0;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_bits_nxt = r_bits + CW'(1);
        unique case (1'b1)
          (w_ba & ~w_bb): begin
            w_gt_nxt    = 1'b1;
            w_state_nxt = S_DONE;
          end
          (~w_ba & w_bb): begin
            w_lt_nxt    = 1'b1;
            w_state_nxt = S_DONE;
          end
          ((w_ba == w_bb) & w_last): begin
            w_eq_nxt    = 1'b1;
            w_state_nxt = S_DONE;
          end
          default: begin
            w_idx_nxt = r_idx - IW'(1);
          end
        endcase
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign gt       = r_gt;
  assign lt       = r_lt;
  assign eq       = r_eq;
  assign bits_cmp = r_bits;

endmodule
